// File: rtl/fram_arbiter_if.sv
// Word-wide valid/ready memory request port shared by the CPU and the persistent-state engine.
// The requester drives valid/addr/wdata/wstrb; the arbiter answers with a one-cycle ready and rdata.
interface fram_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );
endinterface

// File: rtl/fram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port FRAM macro with one-cycle read latency.
// One access in flight: IDLE grants and latches, ISSUE strobes the FRAM, RESP returns ready/rdata.
module fram_arbiter #(
    parameter int FRAM_ADDR_BITS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    fram_arbiter_if.slave             m0,
    fram_arbiter_if.slave             m1,
    output logic                      fram_en,
    output logic [3:0]                fram_wstrb,
    output logic [FRAM_ADDR_BITS-1:0] fram_addr,
    output logic [31:0]               fram_wdata,
    input  logic [31:0]               fram_rdata,
    output logic                      err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        grant_reg, grant_next;
    logic        prio_reg, prio_next;
    logic [31:2] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;

    // Requests gathered into arrays so the grant can index them.
    logic [1:0]  req_valid;
    logic [31:2] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        pick;

    // Byte offset within the word carries no information for word accesses.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{m0.addr[1:0], m1.addr[1:0]};

    assign req_valid    = {m1.valid, m0.valid};
    assign req_addr[0]  = m0.addr[31:2];
    assign req_addr[1]  = m1.addr[31:2];
    assign req_wdata[0] = m0.wdata;
    assign req_wdata[1] = m1.wdata;
    assign req_wstrb[0] = m0.wstrb;
    assign req_wstrb[1] = m1.wstrb;

    // Contention goes to the priority port; a lone request wins outright.
    assign pick = (&req_valid) ? prio_reg : req_valid[1];

    logic out_of_range;
    logic is_read;
    logic [31:0] resp_data;

    assign out_of_range = |addr_reg[31:FRAM_ADDR_BITS+2];
    assign is_read      = (wstrb_reg == 4'b0000);
    assign resp_data    = (is_read && !out_of_range) ? fram_rdata : 32'h0000_0000;

    assign fram_addr  = addr_reg[FRAM_ADDR_BITS+1:2];
    assign fram_wdata = wdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            prio_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            prio_reg  <= prio_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        prio_next  = prio_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        fram_en    = 1'b0;
        fram_wstrb = 4'b0000;
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    grant_next = pick;
                    addr_next  = req_addr[pick];
                    wdata_next = req_wdata[pick];
                    wstrb_next = req_wstrb[pick];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                fram_en    = !out_of_range;
                fram_wstrb = out_of_range ? 4'b0000 : wstrb_reg;
                state_next = RESP;
            end
            RESP: begin
                err        = out_of_range;
                prio_next  = ~grant_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    logic [1:0]  port_ready;
    logic [31:0] port_rdata [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_ready[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
            assign port_rdata[gi] = port_ready[gi] ? resp_data : 32'h0000_0000;
        end
    endgenerate

    assign m0.ready = port_ready[0];
    assign m0.rdata = port_rdata[0];
    assign m1.ready = port_ready[1];
    assign m1.rdata = port_rdata[1];
endmodule

// File: tb/tb_fram_arbiter.sv
// Self-checking bench for fram_arbiter: behavioural FRAM, reference memory, response scoreboard,
// a vector table for arbitration patterns and hand sequences for timing, reset and latching.
module tb_fram_arbiter;
    localparam int AB    = 12;
    localparam int DEPTH = 1 << AB;
    localparam int NV    = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fram_arbiter_if m0_bus ();
    fram_arbiter_if m1_bus ();

    logic          fram_en;
    logic [3:0]    fram_wstrb;
    logic [AB-1:0] fram_addr;
    logic [31:0]   fram_wdata;
    logic [31:0]   fram_rdata = 32'h0;
    logic          err;

    fram_arbiter #(.FRAM_ADDR_BITS(AB)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .fram_en    (fram_en),
        .fram_wstrb (fram_wstrb),
        .fram_addr  (fram_addr),
        .fram_wdata (fram_wdata),
        .fram_rdata (fram_rdata),
        .err        (err)
    );

    // Behavioural FRAM macro driven only by the DUT.
    logic [31:0] fram_mem [DEPTH];
    // Reference contents maintained by the bench from the requests it issues.
    logic [31:0] ref_mem  [DEPTH];

    always @(posedge clk) begin
        if (fram_en) begin
            for (int b = 0; b < 4; b++)
                if (fram_wstrb[b]) fram_mem[fram_addr][8*b +: 8] <= fram_wdata[8*b +: 8];
            fram_rdata <= fram_mem[fram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          v0;
        bit          v1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        bit          first;
    } vec_t;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;
    int resp_cyc [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic expect_txn(input bit p, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        exp_t        e;
        bit          oor;
        logic [AB-1:0] w;
        oor = |a[31:AB+2];
        w   = a[AB+1:2];
        if (!oor && s != 4'b0000)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        e.port  = p;
        e.err   = oor;
        e.rdata = (oor || s != 4'b0000) ? 32'h0 : ref_mem[w];
        sb_q.push_back(e);
    endtask

    task automatic drive(input bit p, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (!p) begin
            m0_bus.valid = 1'b1; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.wstrb = s;
        end else begin
            m1_bus.valid = 1'b1; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.wstrb = s;
        end
    endtask

    task automatic check_resp();
        exp_t        e;
        bit          p;
        logic [31:0] rd;
        if (m0_bus.ready && m1_bus.ready) begin
            check("dual_ready", {30'b0, m1_bus.ready, m0_bus.ready}, 32'd1);
        end else if (m0_bus.ready || m1_bus.ready) begin
            p  = m1_bus.ready;
            rd = p ? m1_bus.rdata : m0_bus.rdata;
            resp_cyc[p] = cyc;
            $display("txn port=%0d rdata=%h err=%0d cycle=%0d", p, rd, err, cyc);
            if (sb_q.size() == 0) begin
                check("spurious_ready", 32'(m0_bus.ready) + 32'(m1_bus.ready), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_port", 32'(p), 32'(e.port));
                check(p ? "m1_rdata" : "m0_rdata", rd, e.rdata);
                check("resp_err", 32'(err), 32'(e.err));
            end
        end else begin
            check("err_without_ready", 32'(err), 32'd0);
        end
        if (!m0_bus.ready) check("m0_rdata_idle", m0_bus.rdata, 32'h0);
        if (!m1_bus.ready) check("m1_rdata_idle", m1_bus.rdata, 32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
        check_resp();
        if (m0_bus.ready) m0_bus.valid = 1'b0;
        if (m1_bus.ready) m1_bus.valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            check("sb_timeout_pending", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
            m0_bus.valid = 1'b0;
            m1_bus.valid = 1'b0;
        end
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            fram_mem[i] = (i == 2) ? 32'h0 : 32'h1000_0000 + 32'(i);
            ref_mem[i]  = (i == 2) ? 32'h0 : 32'h1000_0000 + 32'(i);
        end
        m0_bus.valid = 1'b0; m0_bus.addr = 32'h0; m0_bus.wdata = 32'h0; m0_bus.wstrb = 4'h0;
        m1_bus.valid = 1'b0; m1_bus.addr = 32'h0; m1_bus.wdata = 32'h0; m1_bus.wstrb = 4'h0;
        resp_cyc[0] = 0;
        resp_cyc[1] = 0;

        // Vectors: {v0, v1, a0, a1, d0, d1, s0, s1, first-served port}
        vecs[0] = '{1'b1, 1'b1, 32'h10,   32'h20,   32'h0,        32'h0,        4'h0, 4'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h40,   32'h40,   32'h11223344, 32'h0,        4'hF, 4'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h44,   32'h44,   32'h0,        32'hAABBCCDD, 4'h0, 4'hC, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h44,   32'h4000, 32'h0,        32'h0,        4'h0, 4'h0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h8,    32'h0,    32'h0,        32'h0,        4'h0, 4'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'hC,    32'h3FFC, 32'h0,        32'h0,        4'h0, 4'h0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h4004, 32'h4,    32'hFFFFFFFF, 32'h0,        4'hF, 4'h0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h0,    32'hFFFFFFFC, 32'h0,    32'h0,        4'h0, 4'h0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h40,   32'h7,    32'h0,        32'h0,        4'h0, 4'h0, 1'b0};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_fram_en", 32'(fram_en), 32'd0);
        check("rst_fram_wstrb", 32'(fram_wstrb), 32'd0);
        check("rst_m0_ready", 32'(m0_bus.ready), 32'd0);
        check("rst_m1_ready", 32'(m1_bus.ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // Single read: strobe at N+1, response at N+2
        expect_txn(1'b0, 32'h10, 32'h0, 4'h0);
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        check("t1_fram_en", 32'(fram_en), 32'd1);
        check("t1_fram_addr", 32'(fram_addr), 32'd4);
        check("t1_fram_wstrb", 32'(fram_wstrb), 32'd0);
        check("t1_early_ready", 32'(m0_bus.ready), 32'd0);
        tick();
        check("t1_latency", 32'(sb_q.size()), 32'd0);
        wait_idle(10);

        // Partial write then readback
        expect_txn(1'b1, 32'h8, 32'hDEADBEEF, 4'b0011);
        drive(1'b1, 32'h8, 32'hDEADBEEF, 4'b0011);
        tick();
        check("t3_fram_en", 32'(fram_en), 32'd1);
        check("t3_fram_wstrb", 32'(fram_wstrb), 32'b0011);
        check("t3_fram_addr", 32'(fram_addr), 32'd2);
        check("t3_fram_wdata", fram_wdata, 32'hDEADBEEF);
        wait_idle(10);
        expect_txn(1'b0, 32'h8, 32'h0, 4'h0);
        drive(1'b0, 32'h8, 32'h0, 4'h0);
        wait_idle(10);
        check("t3_readback_ref", ref_mem[2], 32'h0000BEEF);

        // Out-of-range read: no strobe, err with ready, rdata 0
        expect_txn(1'b0, 32'h4000, 32'h0, 4'h0);
        drive(1'b0, 32'h4000, 32'h0, 4'h0);
        tick();
        check("t4_fram_en", 32'(fram_en), 32'd0);
        wait_idle(10);

        // Reset during ISSUE: no ready, priority back to port 0
        drive(1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        check("t5_issue_en", 32'(fram_en), 32'd1);
        reset = 1'b1;
        m0_bus.valid = 1'b0;
        tick();
        check("t5_abort_en", 32'(fram_en), 32'd0);
        check("t5_abort_ready", 32'(m0_bus.ready), 32'd0);
        reset = 1'b0;
        tick();
        check("t5_no_late_ready", 32'(m0_bus.ready), 32'd0);
        expect_txn(1'b0, 32'h24, 32'h0, 4'h0);
        expect_txn(1'b1, 32'h28, 32'h0, 4'h0);
        drive(1'b0, 32'h24, 32'h0, 4'h0);
        drive(1'b1, 32'h28, 32'h0, 4'h0);
        wait_idle(20);

        // Payload changed after grant must not reach the FRAM
        expect_txn(1'b0, 32'h30, 32'h55AA55AA, 4'hF);
        drive(1'b0, 32'h30, 32'h55AA55AA, 4'hF);
        @(posedge clk);
        #1;
        m0_bus.addr  = 32'h34;
        m0_bus.wdata = 32'h0;
        tick();
        check("t6_fram_addr", 32'(fram_addr), 32'd12);
        check("t6_fram_wdata", fram_wdata, 32'h55AA55AA);
        check("t6_fram_wstrb", 32'(fram_wstrb), 32'hF);
        wait_idle(10);
        expect_txn(1'b0, 32'h30, 32'h0, 4'h0);
        drive(1'b0, 32'h30, 32'h0, 4'h0);
        wait_idle(10);
        expect_txn(1'b1, 32'h34, 32'h0, 4'h0);
        drive(1'b1, 32'h34, 32'h0, 4'h0);
        wait_idle(10);

        // Arbitration table from a fresh reset
        do_reset();
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].v0 && vecs[i].v1) begin
                if (!vecs[i].first) begin
                    expect_txn(1'b0, vecs[i].a0, vecs[i].d0, vecs[i].s0);
                    expect_txn(1'b1, vecs[i].a1, vecs[i].d1, vecs[i].s1);
                end else begin
                    expect_txn(1'b1, vecs[i].a1, vecs[i].d1, vecs[i].s1);
                    expect_txn(1'b0, vecs[i].a0, vecs[i].d0, vecs[i].s0);
                end
                drive(1'b0, vecs[i].a0, vecs[i].d0, vecs[i].s0);
                drive(1'b1, vecs[i].a1, vecs[i].d1, vecs[i].s1);
                wait_idle(20);
                check($sformatf("vec%0d_gap", i),
                      32'(resp_cyc[!vecs[i].first] - resp_cyc[vecs[i].first]), 32'd3);
            end else if (vecs[i].v0) begin
                expect_txn(1'b0, vecs[i].a0, vecs[i].d0, vecs[i].s0);
                drive(1'b0, vecs[i].a0, vecs[i].d0, vecs[i].s0);
                wait_idle(10);
            end else begin
                expect_txn(1'b1, vecs[i].a1, vecs[i].d1, vecs[i].s1);
                drive(1'b1, vecs[i].a1, vecs[i].d1, vecs[i].s1);
                wait_idle(10);
            end
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
